// File: rtl/fft_frame_pkg.sv
// Shared types and constants for the FFT frame packer and its helpers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fft_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Config beat layout for the ipsxe_fft cores.
    localparam int CFG_DIR_BIT   = 0;
    localparam int CFG_LEN_LSB   = 1;
    localparam int CFG_LEN_W     = 5;

    // Smallest frame the FFT core accepts (8 points).
    localparam int LOG2_NFFT_MIN = 3;

    // Clamp a requested log2 length into [LOG2_NFFT_MIN, max_log2].
    function automatic logic [CFG_LEN_W-1:0] clamp_log2(
        input logic [CFG_LEN_W-1:0] req,
        input logic [CFG_LEN_W-1:0] max_log2
    );
        logic [CFG_LEN_W-1:0] min_log2;
        min_log2 = CFG_LEN_W'(LOG2_NFFT_MIN);
        if (req < min_log2) begin
            return min_log2;
        end else if (req > max_log2) begin
            return max_log2;
        end
        return req;
    endfunction

endpackage

// File: rtl/fft_axis_out_reg.sv
// Single-stage AXI4-Stream output register carrying tdata and tlast.
// Latency: 1 cycle from load to out_vld.
// Backpressure: in_rdy = !out_vld || out_rdy, so a full register accepts a new
//   beat only in the same cycle its current beat is taken downstream.
// Ports: clk/rst (async active-high); in_vld/in_dat/in_last/in_rdy upstream;
//   out_vld/out_dat/out_last/out_rdy downstream.
module fft_axis_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    input  logic         in_last,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    output logic         out_last,
    input  logic         out_rdy
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;
    logic         last_q, last_d;
    logic         load;

    assign in_rdy = !vld_q || out_rdy;
    assign load   = in_vld && in_rdy;

    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        last_d = last_q;
        if (load) begin
            // A load in the same cycle as a downstream take keeps vld high.
            vld_d  = 1'b1;
            dat_d  = in_dat;
            last_d = in_last;
        end else if (vld_q && out_rdy) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            last_q <= last_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_dat  = dat_q;
    assign out_last = last_q;

endmodule

// File: rtl/fft_frame_packer.sv
// Packs a real sample stream into FFT frames: one config beat, then 2^n complex beats with tlast.
// Latency: 1 cycle from sample acceptance to data beat valid; 2-cycle gap between frames.
// Backpressure: sample ready only in DATA with room in the output register; cfg beat held until taken.
// Ports: i_aclk/i_rst (async active-high); i_start/i_stop/i_inverse/i_nfft_log2/i_frame_count control;
//   i_sample_* / o_sample_ready input stream; o_axi4s_cfg_* and o_axi4s_data_* outputs; o_busy, o_frame_done status.
module fft_frame_packer
    import fft_frame_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int LOG2_NFFT_MAX   = 10,
    parameter int CFG_WIDTH       = 8,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       i_aclk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic                       i_inverse,
    input  logic [4:0]                 i_nfft_log2,
    input  logic [FRAME_CNT_WIDTH-1:0] i_frame_count,
    input  logic                       i_sample_valid,
    input  logic [DATA_WIDTH-1:0]      i_sample_data,
    output logic                       o_sample_ready,
    output logic                       o_axi4s_cfg_tvalid,
    output logic [CFG_WIDTH-1:0]       o_axi4s_cfg_tdata,
    input  logic                       i_axi4s_cfg_tready,
    output logic                       o_axi4s_data_tvalid,
    output logic [2*DATA_WIDTH-1:0]    o_axi4s_data_tdata,
    output logic                       o_axi4s_data_tlast,
    input  logic                       i_axi4s_data_tready,
    output logic                       o_busy,
    output logic                       o_frame_done
);

    localparam logic [CFG_LEN_W-1:0]     MAX_LOG2 = CFG_LEN_W'(LOG2_NFFT_MAX);
    localparam logic [LOG2_NFFT_MAX-1:0] CNT_ONES = '1;

    state_t                     state_q, state_d;
    logic                       inv_q, inv_d;
    logic [CFG_LEN_W-1:0]       len_q, len_d;
    logic [LOG2_NFFT_MAX-1:0]   last_idx_q, last_idx_d;
    logic [LOG2_NFFT_MAX-1:0]   cnt_q, cnt_d;
    logic [FRAME_CNT_WIDTH-1:0] frames_left_q, frames_left_d;
    logic                       stop_pending_q, stop_pending_d;

    logic [CFG_LEN_W-1:0]       len_req;
    logic                       reg_in_vld;
    logic                       reg_in_rdy;
    logic                       accept;
    logic                       is_last;
    logic                       cfg_hs;
    logic [2*DATA_WIDTH-1:0]    beat_dat;

    assign len_req    = clamp_log2(i_nfft_log2, MAX_LOG2);
    assign reg_in_vld = (state_q == DATA) && i_sample_valid;
    assign accept     = reg_in_vld && reg_in_rdy;
    assign is_last    = (cnt_q == last_idx_q);
    assign cfg_hs     = o_axi4s_cfg_tvalid && i_axi4s_cfg_tready;
    // Imaginary half is always zero; real sample sits in the low half.
    assign beat_dat   = {{DATA_WIDTH{1'b0}}, i_sample_data};

    assign o_sample_ready     = (state_q == DATA) && reg_in_rdy;
    assign o_axi4s_cfg_tvalid = (state_q == CFG);
    assign o_busy             = (state_q != IDLE) || o_axi4s_data_tvalid;
    assign o_frame_done       = o_axi4s_data_tvalid && i_axi4s_data_tready && o_axi4s_data_tlast;

    // Config beat is driven only while offered so it reads zero out of reset.
    always_comb begin
        o_axi4s_cfg_tdata = '0;
        if (state_q == CFG) begin
            o_axi4s_cfg_tdata[CFG_DIR_BIT]                = ~inv_q;
            o_axi4s_cfg_tdata[CFG_LEN_LSB +: CFG_LEN_W]   = len_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        inv_d          = inv_q;
        len_d          = len_q;
        last_idx_d     = last_idx_q;
        cnt_d          = cnt_q;
        frames_left_d  = frames_left_q;
        stop_pending_d = stop_pending_q;

        case (state_q)
            IDLE: begin
                if (i_start && !o_busy) begin
                    state_d       = CFG;
                    inv_d         = i_inverse;
                    len_d         = len_req;
                    // N-1 as an all-ones mask of len bits.
                    last_idx_d    = CNT_ONES >> (MAX_LOG2 - len_req);
                    frames_left_d = i_frame_count;
                end
            end
            CFG: begin
                if (cfg_hs) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (accept) begin
                    cnt_d = cnt_q + LOG2_NFFT_MAX'(1);
                    if (is_last) begin
                        cnt_d = '0;
                        // A stop arriving with the last sample still ends the run here.
                        // frames_left of 0 means continuous and is never decremented.
                        if (frames_left_q == FRAME_CNT_WIDTH'(1) || stop_pending_q || i_stop) begin
                            state_d = IDLE;
                        end else begin
                            state_d = CFG;
                            if (frames_left_q != '0) begin
                                frames_left_d = frames_left_q - FRAME_CNT_WIDTH'(1);
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Stops seen while idle are dropped; pending stop clears on return to idle.
        if (state_d == IDLE) begin
            stop_pending_d = 1'b0;
        end else if (i_stop && state_q != IDLE) begin
            stop_pending_d = 1'b1;
        end
    end

    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= IDLE;
            inv_q          <= 1'b0;
            len_q          <= '0;
            last_idx_q     <= '0;
            cnt_q          <= '0;
            frames_left_q  <= '0;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            inv_q          <= inv_d;
            len_q          <= len_d;
            last_idx_q     <= last_idx_d;
            cnt_q          <= cnt_d;
            frames_left_q  <= frames_left_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    fft_axis_out_reg #(
        .W (2*DATA_WIDTH)
    ) u_out_reg (
        .clk      (i_aclk),
        .rst      (i_rst),
        .in_vld   (reg_in_vld),
        .in_dat   (beat_dat),
        .in_last  (is_last),
        .in_rdy   (reg_in_rdy),
        .out_vld  (o_axi4s_data_tvalid),
        .out_dat  (o_axi4s_data_tdata),
        .out_last (o_axi4s_data_tlast),
        .out_rdy  (i_axi4s_data_tready)
    );

endmodule

// File: tb/tb_fft_frame_packer.sv
module tb_fft_frame_packer;

    localparam int DW = 16;
    localparam int LM = 10;
    localparam int CW = 8;
    localparam int FW = 16;

    logic          i_aclk;
    logic          i_rst;
    logic          i_start;
    logic          i_stop;
    logic          i_inverse;
    logic [4:0]    i_nfft_log2;
    logic [FW-1:0] i_frame_count;
    logic          i_sample_valid;
    logic [DW-1:0] i_sample_data;
    logic          o_sample_ready;
    logic          o_axi4s_cfg_tvalid;
    logic [CW-1:0] o_axi4s_cfg_tdata;
    logic          i_axi4s_cfg_tready;
    logic          o_axi4s_data_tvalid;
    logic [2*DW-1:0] o_axi4s_data_tdata;
    logic          o_axi4s_data_tlast;
    logic          i_axi4s_data_tready;
    logic          o_busy;
    logic          o_frame_done;

    fft_frame_packer #(
        .DATA_WIDTH      (DW),
        .LOG2_NFFT_MAX   (LM),
        .CFG_WIDTH       (CW),
        .FRAME_CNT_WIDTH (FW)
    ) dut (
        .i_aclk              (i_aclk),
        .i_rst               (i_rst),
        .i_start             (i_start),
        .i_stop              (i_stop),
        .i_inverse           (i_inverse),
        .i_nfft_log2         (i_nfft_log2),
        .i_frame_count       (i_frame_count),
        .i_sample_valid      (i_sample_valid),
        .i_sample_data       (i_sample_data),
        .o_sample_ready      (o_sample_ready),
        .o_axi4s_cfg_tvalid  (o_axi4s_cfg_tvalid),
        .o_axi4s_cfg_tdata   (o_axi4s_cfg_tdata),
        .i_axi4s_cfg_tready  (i_axi4s_cfg_tready),
        .o_axi4s_data_tvalid (o_axi4s_data_tvalid),
        .o_axi4s_data_tdata  (o_axi4s_data_tdata),
        .o_axi4s_data_tlast  (o_axi4s_data_tlast),
        .i_axi4s_data_tready (i_axi4s_data_tready),
        .o_busy              (o_busy),
        .o_frame_done        (o_frame_done)
    );

    initial i_aclk = 1'b0;
    always #5 i_aclk = ~i_aclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [2*DW-1:0] dat;
        logic            last;
    } beat_t;

    beat_t q[$];          // samples accepted but not yet taken downstream
    bit    m_run;         // a run is in progress
    bit    m_need_cfg;    // current frame still waits for its config beat
    bit    m_stop;
    int    m_len, m_n, m_inv, m_left, m_idx, m_frames;
    bit    acc_flag;      // a sample is accepted at the coming edge

    // observed output statistics, cleared per test
    int          o_cfg, o_beats, o_lasts, o_done;
    logic [7:0]  o_last_cfg;
    logic [31:0] o_last_dat;

    always @(negedge i_aclk) begin
        bit         exp_tv;
        bit         exp_busy;
        bit         exp_rdy;
        bit         exp_fd;
        bit         acc;
        bit         is_last;
        int         l;
        if (i_rst) begin
            check("rst_sample_ready", o_sample_ready, 0);
            check("rst_cfg_tvalid", o_axi4s_cfg_tvalid, 0);
            check("rst_cfg_tdata", o_axi4s_cfg_tdata, 0);
            check("rst_data_tvalid", o_axi4s_data_tvalid, 0);
            check("rst_data_tdata", o_axi4s_data_tdata, 0);
            check("rst_data_tlast", o_axi4s_data_tlast, 0);
            check("rst_busy", o_busy, 0);
            check("rst_frame_done", o_frame_done, 0);
            q.delete();
            m_run = 0; m_need_cfg = 0; m_stop = 0; m_idx = 0; m_frames = 0;
            acc_flag = 0;
        end else begin
            exp_tv   = (q.size() > 0);
            exp_busy = m_run || exp_tv;
            exp_rdy  = m_run && !m_need_cfg && (!exp_tv || i_axi4s_data_tready);
            exp_fd   = exp_tv && i_axi4s_data_tready && q[0].last;

            check("busy", o_busy, exp_busy);
            check("cfg_tvalid", o_axi4s_cfg_tvalid, m_run && m_need_cfg);
            if (m_run && m_need_cfg)
                check("cfg_tdata", o_axi4s_cfg_tdata, 64'((m_len << 1) | (m_inv ? 0 : 1)));
            check("sample_ready", o_sample_ready, exp_rdy);
            check("data_tvalid", o_axi4s_data_tvalid, exp_tv);
            if (exp_tv) begin
                check("data_tdata", o_axi4s_data_tdata, q[0].dat);
                check("data_tlast", o_axi4s_data_tlast, q[0].last);
            end
            check("frame_done", o_frame_done, exp_fd);

            if (o_axi4s_cfg_tvalid && i_axi4s_cfg_tready) begin
                o_cfg++;
                o_last_cfg = o_axi4s_cfg_tdata;
            end
            if (o_axi4s_data_tvalid && i_axi4s_data_tready) begin
                o_beats++;
                o_last_dat = o_axi4s_data_tdata;
                if (o_axi4s_data_tlast) o_lasts++;
            end
            if (o_frame_done) o_done++;

            // advance the model by one edge
            if (exp_tv && i_axi4s_data_tready) void'(q.pop_front());
            if (m_run && m_need_cfg && i_axi4s_cfg_tready) m_need_cfg = 0;

            acc = i_sample_valid && exp_rdy;
            acc_flag = acc;
            if (acc) begin
                is_last = (m_idx == m_n - 1);
                q.push_back('{dat: {16'h0, i_sample_data}, last: is_last});
                m_idx++;
                if (is_last) begin
                    m_frames++;
                    if (m_stop || i_stop || m_left == 1) begin
                        m_run = 0;
                    end else begin
                        m_need_cfg = 1;
                        m_idx = 0;
                        if (m_left != 0) m_left--;
                    end
                end
            end
            if (i_stop && m_run) m_stop = 1;

            if (i_start && !exp_busy) begin
                l = int'(i_nfft_log2);
                if (l < 3) l = 3;
                if (l > LM) l = LM;
                m_run = 1; m_need_cfg = 1; m_stop = 0;
                m_len = l; m_n = 1 << l; m_inv = int'(i_inverse);
                m_left = int'(i_frame_count); m_idx = 0; m_frames = 0;
            end
        end
    end

    // ---------------- stimulus sources ----------------
    bit          src_en, src_ramp, drdy_rand, cfg_rdy;
    int          src_pct;
    logic [DW-1:0] src_val;

    initial begin
        i_sample_valid = 0; i_sample_data = 0;
        i_axi4s_data_tready = 1; i_axi4s_cfg_tready = 1;
        forever begin
            @(posedge i_aclk); #1;
            if (acc_flag) src_val = src_ramp ? src_val + 16'd1 : 16'($urandom);
            i_sample_valid = src_en && ($urandom_range(99) < src_pct);
            i_sample_data = src_val;
            i_axi4s_data_tready = drdy_rand ? 1'($urandom_range(1)) : 1'b1;
            i_axi4s_cfg_tready = cfg_rdy;
        end
    end

    task automatic tick();
        @(posedge i_aclk); #2;
    endtask

    task automatic do_start(input bit inv, input logic [4:0] l2, input logic [FW-1:0] cnt);
        i_inverse = inv; i_nfft_log2 = l2; i_frame_count = cnt;
        i_start = 1; tick(); i_start = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((m_run || q.size() > 0) && n < budget) begin tick(); n++; end
        if (n >= budget) check("wait_done_timeout", 1, 0);
        tick();
    endtask

    task automatic clear_obs();
        o_cfg = 0; o_beats = 0; o_lasts = 0; o_done = 0;
        o_last_cfg = 0; o_last_dat = 0;
    endtask

    initial begin
        int n;
        i_rst = 1; i_start = 0; i_stop = 0; i_inverse = 0;
        i_nfft_log2 = 0; i_frame_count = 0;
        src_en = 0; src_ramp = 1; drdy_rand = 0; cfg_rdy = 1; src_pct = 100; src_val = 0;
        clear_obs();
        repeat (3) tick();
        i_rst = 0;
        tick();
        check("post_reset_busy", o_busy, 0);

        // single 256-point FFT frame, ramp 0..255
        clear_obs(); src_val = 0; src_en = 1;
        do_start(0, 5'd8, 16'd1);
        wait_done(2000);
        check("t1_cfg_count", o_cfg, 1);
        check("t1_cfg_value", o_last_cfg, 8'h11);
        check("t1_beats", o_beats, 256);
        check("t1_lasts", o_lasts, 1);
        check("t1_done", o_done, 1);
        check("t1_final_beat", o_last_dat, 32'h0000_00FF);
        check("t1_busy_low", o_busy, 0);

        // back-pressure, random data, two 16-point frames
        clear_obs(); src_ramp = 0; src_pct = 70; drdy_rand = 1;
        do_start(0, 5'd4, 16'd2);
        wait_done(3000);
        check("t2_beats", o_beats, 32);
        check("t2_lasts", o_lasts, 2);
        check("t2_done", o_done, 2);
        check("t2_cfg_count", o_cfg, 2);
        check("t2_cfg_value", o_last_cfg, 8'h09);

        // continuous IFFT, stop during frame 3
        clear_obs(); src_ramp = 1; src_val = 0; src_pct = 100; drdy_rand = 0;
        do_start(1, 5'd3, 16'd0);
        n = 0;
        while (!(m_frames == 2 && m_idx >= 3) && n < 500) begin tick(); n++; end
        if (n >= 500) check("t3_wait_timeout", 1, 0);
        i_stop = 1; tick(); i_stop = 0;
        wait_done(500);
        check("t3_cfg_count", o_cfg, 3);
        check("t3_cfg_value", o_last_cfg, 8'h06);
        check("t3_beats", o_beats, 24);
        check("t3_lasts", o_lasts, 3);

        // stop while idle is discarded
        i_stop = 1; tick(); i_stop = 0; tick();
        clear_obs();
        do_start(0, 5'd3, 16'd2);
        wait_done(500);
        check("t3b_frames", o_lasts, 2);

        // clamping
        clear_obs();
        do_start(0, 5'd1, 16'd1);
        wait_done(500);
        check("t4_small_beats", o_beats, 8);
        check("t4_small_cfg", o_last_cfg, 8'h07);
        clear_obs();
        do_start(0, 5'd20, 16'd1);
        wait_done(3000);
        check("t4_big_beats", o_beats, 1024);
        check("t4_big_cfg", o_last_cfg, 8'h15);

        // config stall
        clear_obs(); cfg_rdy = 0;
        do_start(0, 5'd3, 16'd1);
        repeat (5) begin
            check("t5_cfg_hold_vld", o_axi4s_cfg_tvalid, 1);
            check("t5_cfg_hold_dat", o_axi4s_cfg_tdata, 8'h07);
            check("t5_rdy_held_low", o_sample_ready, 0);
            tick();
        end
        cfg_rdy = 1;
        wait_done(500);
        check("t5_beats", o_beats, 8);

        // reset mid-frame at sample 100, then a fresh run
        src_pct = 100;
        do_start(0, 5'd8, 16'd1);
        n = 0;
        while (m_idx < 100 && n < 1000) begin tick(); n++; end
        if (n >= 1000) check("t6_wait_timeout", 1, 0);
        i_rst = 1; tick();
        check("t6_rst_data_tvalid", o_axi4s_data_tvalid, 0);
        check("t6_rst_busy", o_busy, 0);
        i_rst = 0; tick();
        clear_obs();
        do_start(0, 5'd3, 16'd1);
        wait_done(500);
        check("t6_cfg_count", o_cfg, 1);
        check("t6_beats", o_beats, 8);
        check("t6_lasts", o_lasts, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_frame_packer.md
# fft_frame_packer

Synthesizable front end that packs a real-valued audio sample stream into AXI4-Stream FFT frames for `ipsxe_fft` cores. It issues one config beat (direction and length) per frame, then forwards exactly 2^n samples as complex beats with `tlast` on the final one. Frame length, direction and frame count are set at run time, and the block honours back-pressure on every channel. It sits between the audio FIR/ADC path and the FFT core, replacing the fixed 256-point hand-driven stimulus.

## Interface
Parameters:
- `DATA_WIDTH`, 16: real sample width; output beat is 2*DATA_WIDTH.
- `LOG2_NFFT_MAX`, 10: largest supported frame length (2^10 = 1024 points).
- `CFG_WIDTH`, 8: config tdata width.
- `FRAME_CNT_WIDTH`, 16: width of the frame-count request.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `i_aclk`, in, 1: clock.
  - `i_rst`, in, 1: asynchronous, active-high reset.
- Control:
  - `i_start`, in, 1: pulse that launches a run; ignored while `o_busy`.
  - `i_stop`, in, 1: pulse that ends a continuous run after the current frame.
  - `i_inverse`, in, 1: 0 = FFT, 1 = IFFT; sampled at start.
  - `i_nfft_log2`, in, 5: log2 of the frame length; sampled at start; clamped to [3, LOG2_NFFT_MAX].
  - `i_frame_count`, in, FRAME_CNT_WIDTH: frames per run; 0 = continuous; sampled at start.
- Sample input:
  - `i_sample_valid`, in, 1: input beat valid.
  - `i_sample_data`, in, DATA_WIDTH: signed real sample.
  - `o_sample_ready`, out, 1: input beat accepted when high together with `i_sample_valid`.
- Config output:
  - `o_axi4s_cfg_tvalid`, out, 1: config beat valid.
  - `o_axi4s_cfg_tdata`, out, CFG_WIDTH: bit0 = 1 for FFT / 0 for IFFT; bits[5:1] = log2 length; other bits 0.
  - `i_axi4s_cfg_tready`, in, 1: config beat accepted.
- Data output:
  - `o_axi4s_data_tvalid`, out, 1: data beat valid.
  - `o_axi4s_data_tdata`, out, 2*DATA_WIDTH: {imag = 0, real = sample}, real in the low half.
  - `o_axi4s_data_tlast`, out, 1: marks the final beat of a frame.
  - `i_axi4s_data_tready`, in, 1: data beat accepted.
- Status:
  - `o_busy`, out, 1: run in progress or output beat pending.
  - `o_frame_done`, out, 1: one-cycle pulse per completed frame.

## Operation
- FSM states:
  - IDLE: waits for `i_start`.
  - CFG: holds the config beat until it is accepted.
  - DATA: forwards samples for one frame.
- Transitions:
  - IDLE → CFG on `i_start`; latch mode, clamped length and frame count.
  - CFG → DATA on the config handshake.
  - DATA, when the input sample with `cnt == N-1` is accepted:
    - → IDLE if `frames_left == 1` or a stop is pending;
    - otherwise → CFG, decrementing `frames_left` unless the run is continuous.
- A config beat is re-sent before every frame.
- Sample counter `cnt` is log2-max wide, clears on entry to DATA, and increments on each accepted input beat. It never wraps inside a frame.
- Output register (single stage):
  - `o_sample_ready = (state==DATA) && (!o_axi4s_data_tvalid || i_axi4s_data_tready)`.
  - The register loads on input acceptance; `tlast` loads as `cnt == N-1`.
  - `tvalid` clears on an output handshake when no new load occurs.
- Stop handling: `i_stop` sets a sticky `stop_pending`, cleared when the FSM enters IDLE. A stop in IDLE is discarded.
- `o_busy = (state != IDLE) || o_axi4s_data_tvalid`.
- `o_frame_done` pulses on the output handshake of a beat with `tlast`.
- Data is passed through bit-exact; no scaling. The imaginary half is always 0.
- Input stall (`i_sample_valid` low) inserts bubbles only; no underrun padding.

## Timing
- Reset: all outputs 0 (`o_sample_ready` 0, both tvalids 0, tdata 0, tlast 0, `o_busy` 0, `o_frame_done` 0). State goes to IDLE and counters clear. A reset mid-frame drops the partial frame with no `tlast`.
- `i_start` at edge k → `o_axi4s_cfg_tvalid` high from edge k+1.
- Config handshake at edge c → `o_sample_ready` may rise after edge c.
- Input accepted at edge d → output beat valid after edge d; latency 1 cycle.
- Full throughput of 1 beat/cycle while `i_axi4s_data_tready` stays high.
- Frame gap: with both readies constantly high, the next frame's first input beat is accepted 2 cycles after the previous last input beat (CFG + handshake).
- Simultaneous output handshake and new load: the register updates and `tvalid` stays high.
- `i_start` during `o_busy` is ignored.
- `i_stop` on the same cycle as the last-sample acceptance ends the run at that frame.

## Structure
- Package `fft_frame_pkg` holds:
  - state enum {IDLE, CFG, DATA};
  - `CFG_DIR_BIT = 0`, `CFG_LEN_LSB = 1`, `CFG_LEN_W = 5`;
  - `LOG2_NFFT_MIN = 3`.
- One sub-module, `fft_axis_out_reg`: the single-stage AXI4-Stream register with tdata and tlast, reused by later FFT blocks.

## Test plan
- Single 256-point FFT frame (`log2=8`, count 1, both readies held high, ramp 0..255): one cfg beat of 0x11 ({len=8, FFT}); 256 data beats with real = 0..255 and imag = 0; `tlast` only on 255; one `o_frame_done`; `o_busy` low 1 cycle after the last beat.
- Back-pressure: toggle `i_axi4s_data_tready` pseudo-randomly on a 16-point frame: no beat lost or duplicated; data stable while stalled; `tlast` on beat 15.
- Continuous IFFT with stop (`log2=3`, count 0, `i_stop` mid-frame 3): exactly 3 frames with cfg 0x06 each; FSM returns to IDLE after frame 3.
- Clamping: `log2=1` gives 8-point frames and cfg len 3; `log2=20` with `LOG2_NFFT_MAX=10` gives 1024-point frames.
- Config stall: hold `i_axi4s_cfg_tready` low for 5 cycles: cfg tvalid held with stable tdata; `o_sample_ready` stays 0 until the handshake.
- Reset mid-frame at sample 100: all outputs 0 next cycle; a new start then yields a fresh cfg beat and a full frame.
